// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light monitor: lamp phases, fault causes
// and monitor FSM states.
package traffic_pkg;

  localparam logic [1:0] PH_AG = 2'd0;
  localparam logic [1:0] PH_AY = 2'd1;
  localparam logic [1:0] PH_BG = 2'd2;
  localparam logic [1:0] PH_BY = 2'd3;

  localparam logic [2:0] F_NONE        = 3'd0;
  localparam logic [2:0] F_ENCODING    = 3'd1;
  localparam logic [2:0] F_CONFLICT    = 3'd2;
  localparam logic [2:0] F_SEQUENCE    = 3'd3;
  localparam logic [2:0] F_SHORT_GREEN = 3'd4;
  localparam logic [2:0] F_YELLOW_LEN  = 3'd5;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } mon_state_t;

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp lines from the controller plus the monitor's fault/phase status.
// master = controller/host side, slave = monitor side.
interface traffic_light_monitor_if;
  logic       ra, ya, ga;
  logic       rb, yb, gb;
  logic       fault_clr;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] phase;
  logic       phase_valid;
  logic       flash;

  modport master (
    output ra, ya, ga, rb, yb, gb, fault_clr,
    input  fault, fault_code, phase, phase_valid, flash
  );

  modport slave (
    input  ra, ya, ga, rb, yb, gb, fault_clr,
    output fault, fault_code, phase, phase_valid, flash
  );
endinterface

// File: rtl/traffic_light_monitor_lamp_decode.sv
// Combinational decode of the six lamp lines into a phase plus
// encoding/conflict flags; kept standalone so a lamp driver can reuse it.
module lamp_decode
  import traffic_pkg::*;
(
  input  logic       i_ra,
  input  logic       i_ya,
  input  logic       i_ga,
  input  logic       i_rb,
  input  logic       i_yb,
  input  logic       i_gb,
  output logic [1:0] o_phase,
  output logic       o_pattern_legal,
  output logic       o_enc_err,
  output logic       o_conflict
);

  logic [5:0] w_lamps;

  assign w_lamps    = {i_ra, i_ya, i_ga, i_rb, i_yb, i_gb};
  assign o_enc_err  = !$onehot({i_ra, i_ya, i_ga}) || !$onehot({i_rb, i_yb, i_gb});
  assign o_conflict = (i_ga | i_ya) & (i_gb | i_yb);

  always_comb begin
    o_phase         = PH_AG;
    o_pattern_legal = 1'b1;
    case (w_lamps)
      6'b001_100: o_phase = PH_AG;
      6'b010_100: o_phase = PH_AY;
      6'b100_001: o_phase = PH_BG;
      6'b100_010: o_phase = PH_BY;
      default:    o_pattern_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Sequence/conflict monitor on the controller lamp outputs: tracks the phase,
// latches the first violation as a sticky fault and drives a flash strobe.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN_A   = 6,
  parameter int unsigned MIN_GREEN_B   = 5,
  parameter int unsigned YELLOW_CYCLES = 1,
  parameter int unsigned FLASH_HALF    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  traffic_light_monitor_if.slave   mon
);

  mon_state_t r_state, w_nx_state;
  logic [1:0] r_phase, w_nx_phase;
  logic [7:0] r_cnt, w_nx_cnt;
  logic       r_first, w_nx_first;
  logic       r_fault, w_nx_fault;
  logic [2:0] r_code, w_nx_code;
  logic       r_valid, w_nx_valid;
  logic       r_flash, w_nx_flash;
  logic [7:0] r_fcnt, w_nx_fcnt;

  logic [1:0] w_phase;
  logic       w_legal;
  logic       w_enc_err;
  logic       w_conflict;
  logic [2:0] w_viol;

  lamp_decode u_lamp_decode (
    .i_ra            (mon.ra),
    .i_ya            (mon.ya),
    .i_ga            (mon.ga),
    .i_rb            (mon.rb),
    .i_yb            (mon.yb),
    .i_gb            (mon.gb),
    .o_phase         (w_phase),
    .o_pattern_legal (w_legal),
    .o_enc_err       (w_enc_err),
    .o_conflict      (w_conflict)
  );

  // Violation of the current sample in priority order. An all-red sample
  // passes encoding/conflict but is no phase, so in RUN it counts as sequence.
  always_comb begin
    w_viol = F_NONE;
    if (w_enc_err) begin
      w_viol = F_ENCODING;
    end else if (w_conflict) begin
      w_viol = F_CONFLICT;
    end else if (r_state == ST_RUN) begin
      if (!w_legal) begin
        w_viol = F_SEQUENCE;
      end else if (w_phase != r_phase) begin
        if (w_phase != r_phase + 2'd1) begin
          w_viol = F_SEQUENCE;
        end else if (!r_first) begin
          case (r_phase)
            PH_AG:   if (r_cnt < 8'(MIN_GREEN_A))   w_viol = F_SHORT_GREEN;
            PH_BG:   if (r_cnt < 8'(MIN_GREEN_B))   w_viol = F_SHORT_GREEN;
            default: if (r_cnt < 8'(YELLOW_CYCLES)) w_viol = F_YELLOW_LEN;
          endcase
        end
      end else if (!r_first && (r_phase == PH_AY || r_phase == PH_BY) &&
                   r_cnt >= 8'(YELLOW_CYCLES)) begin
        w_viol = F_YELLOW_LEN;
      end
    end
  end

  always_comb begin
    w_nx_state = r_state;
    w_nx_phase = r_phase;
    w_nx_cnt   = r_cnt;
    w_nx_first = r_first;
    w_nx_fault = r_fault;
    w_nx_code  = r_code;
    w_nx_valid = r_valid;
    w_nx_flash = 1'b0;
    w_nx_fcnt  = 8'd0;
    case (r_state)
      ST_SYNC: begin
        if (w_viol != F_NONE) begin
          if (!mon.fault_clr) begin
            w_nx_state = ST_FAULT;
            w_nx_fault = 1'b1;
            w_nx_code  = w_viol;
            w_nx_valid = 1'b0;
            w_nx_flash = 1'b1;
          end
        end else if (w_legal) begin
          w_nx_state = ST_RUN;
          w_nx_phase = w_phase;
          w_nx_cnt   = 8'd1;
          w_nx_first = 1'b1;
          w_nx_valid = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_viol != F_NONE) begin
          w_nx_valid = 1'b0;
          if (mon.fault_clr) begin
            w_nx_state = ST_SYNC;
          end else begin
            w_nx_state = ST_FAULT;
            w_nx_fault = 1'b1;
            w_nx_code  = w_viol;
            w_nx_flash = 1'b1;
          end
        end else if (w_phase != r_phase) begin
          w_nx_phase = w_phase;
          w_nx_cnt   = 8'd1;
          w_nx_first = 1'b0;
        end else if (r_cnt != 8'hFF) begin
          w_nx_cnt = r_cnt + 8'd1;
        end
      end
      ST_FAULT: begin
        if (mon.fault_clr) begin
          w_nx_state = ST_SYNC;
          w_nx_fault = 1'b0;
          w_nx_code  = F_NONE;
          w_nx_valid = 1'b0;
        end else if (r_fcnt == 8'(FLASH_HALF - 1)) begin
          w_nx_flash = ~r_flash;
        end else begin
          w_nx_flash = r_flash;
          w_nx_fcnt  = r_fcnt + 8'd1;
        end
      end
      default: w_nx_state = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_SYNC;
      r_phase <= PH_AG;
      r_cnt   <= 8'd0;
      r_first <= 1'b0;
      r_fault <= 1'b0;
      r_code  <= F_NONE;
      r_valid <= 1'b0;
      r_flash <= 1'b0;
      r_fcnt  <= 8'd0;
    end else begin
      r_state <= w_nx_state;
      r_phase <= w_nx_phase;
      r_cnt   <= w_nx_cnt;
      r_first <= w_nx_first;
      r_fault <= w_nx_fault;
      r_code  <= w_nx_code;
      r_valid <= w_nx_valid;
      r_flash <= w_nx_flash;
      r_fcnt  <= w_nx_fcnt;
    end
  end

  assign mon.fault       = r_fault;
  assign mon.fault_code  = r_code;
  assign mon.phase       = r_phase;
  assign mon.phase_valid = r_valid;
  assign mon.flash       = r_flash;

endmodule
